// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC sequencing, single-outstanding imem fetch and decode queue
// Optional FETCH_STALL_CNT_EN adds a saturating stall_cnt output.
module fetch_sequencer #(
    parameter int BUF_DEPTH = 2,
    parameter int PC_STEP   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    output logic        pc_write,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          reserved_q;
    logic [31:0]   req_pc_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   mem_instr_q [BUF_DEPTH];
    logic [31:0]   mem_pc_q    [BUF_DEPTH];
    logic [31:0]   last_instr_q, last_pc_q;

    logic          redirect_act, handshake, push, pop;
    logic [CW-1:0] occupancy;

    // Redirects are ignored in IDLE so a pulse during reset recovery cannot move the PC.
    assign redirect_act   = redirect_valid && (state_q != S_IDLE);
    assign occupancy      = count_q + CW'(reserved_q);
    assign imem_req_valid = (state_q == S_REQ) && (occupancy < DEPTH_C) && !redirect_valid;
    assign imem_req_addr  = pc_in;
    assign handshake      = imem_req_valid && imem_req_ready;
    assign push           = (state_q == S_WAIT) && imem_resp_valid && !redirect_valid;
    assign id_valid       = (count_q != '0);
    assign pop            = id_valid && id_ready;
    assign pc_write       = redirect_act || handshake;
    assign pc_next        = redirect_act ? redirect_target :
                            handshake    ? pc_in + 32'(PC_STEP) : 32'd0;
    assign id_instr       = id_valid ? mem_instr_q[rd_ptr_q] : last_instr_q;
    assign id_pc          = id_valid ? mem_pc_q[rd_ptr_q]    : last_pc_q;

    always_comb begin
        state_d = state_q;
        if (state_q == S_IDLE) begin
            state_d = S_REQ;
        end else if (redirect_act) begin
            // A response already on the bus this cycle is the in-flight one; nothing left to drop.
            state_d = ((state_q == S_WAIT || state_q == S_DROP) && !imem_resp_valid) ? S_DROP : S_REQ;
        end else begin
            case (state_q)
                S_REQ:   if (handshake)       state_d = S_WAIT;
                S_WAIT:  if (imem_resp_valid) state_d = S_REQ;
                S_DROP:  if (imem_resp_valid) state_d = S_REQ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            reserved_q <= 1'b0;
            req_pc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (redirect_act || push) begin
                reserved_q <= 1'b0;
            end else if (handshake) begin
                reserved_q <= 1'b1;
            end
            if (handshake) begin
                req_pc_q <= pc_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_instr_q <= 32'd0;
            last_pc_q    <= 32'd0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_instr_q[i] <= 32'd0;
                mem_pc_q[i]    <= 32'd0;
            end
        end else begin
            if (id_valid) begin
                last_instr_q <= mem_instr_q[rd_ptr_q];
                last_pc_q    <= mem_pc_q[rd_ptr_q];
            end
            if (redirect_act) begin
                rd_ptr_q <= wr_ptr_q;
                count_q  <= '0;
            end else begin
                if (push) begin
                    mem_instr_q[wr_ptr_q] <= imem_resp_data;
                    mem_pc_q[wr_ptr_q]    <= req_pc_q;
                    wr_ptr_q              <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic stall_inc;
    assign stall_inc = ((state_q == S_REQ) && (count_q == DEPTH_C)) ||
                       (state_q == S_WAIT) || (state_q == S_DROP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 32'd0;
        end else if (redirect_act) begin
            stall_cnt <= 32'd0;
        end else if (stall_inc && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized check of fetch_sequencer against a transaction-level model
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic        pc_write;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(.BUF_DEPTH(2), .PC_STEP(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc_in),
        .pc_next         (pc_next),
        .pc_write        (pc_write),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .id_valid        (id_valid),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_ready        (id_ready)
    );

    always #5 clk = ~clk;

    // External PC register, fed by the DUT.
    always @(posedge clk or posedge reset) begin
        if (reset) pc_in <= 32'd0;
        else if (pc_write) pc_in <= pc_next;
    end

    // Model: fetched instructions waiting for decode, plus one outstanding fetch.
    logic [31:0] mq_instr[$];
    logic [31:0] mq_pc[$];
    bit          m_started;
    bit          m_out;
    bit          m_drop;
    logic [31:0] m_req_pc;
    logic [31:0] m_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq_instr.delete();
        mq_pc.delete();
        m_started = 0;
        m_out     = 0;
        m_drop    = 0;
        m_req_pc  = 32'd0;
        m_pc      = 32'd0;
    endtask

    task automatic step(input bit rv, input logic [31:0] tgt, input bit rdy, input bit rsp, input bit idr);
        bit          redir, e_req, e_hs, e_pcw;
        logic [31:0] e_next, data;
        data            = $urandom;
        redirect_valid  = rv;
        redirect_target = tgt;
        imem_req_ready  = rdy;
        imem_resp_valid = rsp;
        imem_resp_data  = data;
        id_ready        = idr;
        #4;
        redir  = rv && m_started;
        e_req  = m_started && !m_out && (mq_pc.size() < 2) && !rv;
        e_hs   = e_req && rdy;
        e_pcw  = redir || e_hs;
        e_next = redir ? tgt : m_pc + 32'd4;
        check("req_valid", {31'd0, imem_req_valid}, {31'd0, e_req});
        check("req_addr", imem_req_addr, m_pc);
        check("pc_write", {31'd0, pc_write}, {31'd0, e_pcw});
        if (e_pcw) check("pc_next", pc_next, e_next);
        check("id_valid", {31'd0, id_valid}, {31'd0, mq_pc.size() != 0});
        if (mq_pc.size() != 0) begin
            check("id_pc", id_pc, mq_pc[0]);
            check("id_instr", id_instr, mq_instr[0]);
        end
        if (redir) begin
            mq_instr.delete();
            mq_pc.delete();
            if (m_out && !rsp) m_drop = 1;
            else begin m_out = 0; m_drop = 0; end
        end else begin
            if (mq_pc.size() != 0 && idr) begin
                void'(mq_instr.pop_front());
                void'(mq_pc.pop_front());
            end
            if (m_out && rsp) begin
                if (!m_drop) begin
                    mq_instr.push_back(data);
                    mq_pc.push_back(m_req_pc);
                end
                m_out  = 0;
                m_drop = 0;
            end
            if (e_hs) begin
                m_out    = 1;
                m_req_pc = m_pc;
            end
        end
        if (e_pcw) m_pc = e_next;
        m_started = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_pc_write", {31'd0, pc_write}, 32'd0);
        check("rst_pc_next", pc_next, 32'd0);
        check("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check("rst_id_instr", id_instr, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset           = 1'b0;
        redirect_valid  = 0;
        redirect_target = 0;
        imem_req_ready  = 0;
        imem_resp_valid = 0;
        imem_resp_data  = 0;
        id_ready        = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Streaming: response one cycle after each request, decode always ready.
        for (int i = 0; i < 12; i++) step(0, 0, 1, m_out, 1);

        // Decode stalled: queue fills and fetch stops.
        do_reset();
        for (int i = 0; i < 10; i++) step(0, 0, 1, m_out, 0);
        check("full_pc_frozen", imem_req_addr, 32'h8);
        for (int i = 0; i < 6; i++) step(0, 0, 1, m_out, 1);

        // Redirect while waiting on the response for 4.
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 1, m_out, 1);
        step(0, 0, 0, 0, 0);
        step(1, 32'h100, 1, 0, 0);
        check("flush_id_valid", {31'd0, id_valid}, 32'd0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, m_out, 1);

        // Redirect coincident with a response.
        while (!m_out) step(0, 0, 1, 0, 1);
        step(1, 32'h200, 1, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 1, m_out, 1);

        // PC wrap at the top of the address space.
        step(1, 32'hFFFF_FFFC, 0, m_out, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 1, m_out, 1);

        // Reset while waiting; the stale response must not be queued.
        while (!m_out) step(0, 0, 1, 0, 1);
        do_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check("stale_id_valid", {31'd0, id_valid}, 32'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, m_out, 1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] tgt;
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom % 6 == 0) tgt = 32'hFFFF_FFF8;
            step(($urandom % 12) == 0, tgt, ($urandom % 4) != 0,
                 m_out ? (($urandom % 3) == 0) : (($urandom % 8) == 0),
                 ($urandom % 3) != 0);
            if ($urandom % 700 == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
